instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Reader side of the PC datapath: owns the 16-bit PC, issues word reads to instruction memory over a req/gnt/rvalid handshake, and presents each fetched instruction to decode over a valid/ready handshake.
- Sits between the PC block and the decode stage.
- Multi-cycle with one outstanding memory request; supports redirect (branch/jump target) at any time.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
PC_STEP, 16'h0001, PC increment per accepted request (word addressing)

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
enable  input  1  fetch permitted
redirect  input  1  load redirect_pc, squash current fetch
redirect_pc  input  16  redirect target
mem_req  output  1  read request
mem_addr  output  16  read address
mem_gnt  input  1  request accepted this cycle
mem_rvalid  input  1  read data valid
mem_rdata  input  16  read data
instr_valid  output  1  instruction available
instr  output  16  fetched instruction
instr_pc  output  16  address of instr
instr_ready  input  1  decode accepts instr
pc  output  16  next fetch address

Behaviour:
- One clock, `clock`. Reset is asynchronous, active-low, on `reset_n`.
- Reset (async, immediate): state=IDLE, pc=RESET_PC, mem_addr=RESET_PC, mem_req=0, instr_valid=0, instr=0, instr_pc=0, discard=0.
- All outputs are registered.
- States: IDLE, REQ, WAIT, HOLD.
- IDLE: if enable, go to REQ next cycle; otherwise stay.
- REQ:
  - mem_req=1, mem_addr=pc, both held stable until mem_gnt.
  - On gnt: go to WAIT, latch req_addr=pc, pc<=pc+PC_STEP (mod 2^16, 0xFFFF wraps to 0x0000).
  - enable is not sampled in REQ.
- WAIT:
  - mem_req=0.
  - On mem_rvalid with discard=0: instr<=mem_rdata, instr_pc<=req_addr, instr_valid<=1, go to HOLD.
  - On mem_rvalid with discard=1: drop data, clear discard, go to REQ if enable, else IDLE.
- HOLD:
  - instr_valid=1; instr and instr_pc stable.
  - On instr_ready: instr_valid<=0, go to REQ if enable, else IDLE.
- mem_rvalid outside WAIT is ignored.
- Minimum fetch period: 3 cycles (gnt same cycle as req, rvalid next cycle, ready in HOLD).
- Redirect has highest priority in every state; pc<=redirect_pc and instr_valid<=0 next cycle.
  - IDLE/HOLD: go to REQ if enable, else IDLE.
  - A HOLD with instr_ready in the same cycle counts as a completed transfer.
  - REQ without gnt: stay in REQ; mem_addr<=redirect_pc next cycle; mem_req stays 1.
  - REQ with gnt same cycle: go to WAIT with discard=1. pc takes redirect_pc, not the increment.
  - WAIT: discard<=1 (a redirect during a discard keeps discard=1); stay in WAIT.
- A second redirect before REQ overwrites pc; the last redirect wins.
- enable deassert never aborts an in-flight request; it only blocks new requests.

Optional Feature:
- Macro: FETCH_PERF_COUNT_EN.
- Defined: adds outputs fetch_count[15:0] and stall_count[15:0], both reset to 0 and wrapping at 2^16.
  - fetch_count increments on each instr_valid&instr_ready.
  - stall_count increments on each cycle in REQ without gnt, in WAIT, or in HOLD with instr_ready=0.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
1. RESET_PC=0x0010, enable=1, memory gnts immediately and returns rvalid next cycle with data=addr^0xA5A5, instr_ready=1.
   -> mem_addr sequence 0x0010, 0x0011, 0x0012; instr/instr_pc = (0xA5B5, 0x0010), (0xA5B4, 0x0011), (0xA5B7, 0x0012); one instr every 3 cycles.
2. Hold instr_ready=0 for 5 cycles in HOLD.
   -> instr_valid=1 and instr/instr_pc unchanged for all 5 cycles; mem_req=0 throughout; next mem_req 1 cycle after ready.
3. Redirect to 0x0200 in WAIT for address 0x0011; rvalid arrives 2 cycles later.
   -> that data is never shown (instr_valid stays 0); next mem_addr=0x0200; first instr_pc=0x0200.
4. Redirect to 0xFFFF, then two fetches.
   -> mem_addr 0xFFFF then 0x0000; instr_pc 0xFFFF then 0x0000.
5. Drive reset_n low mid-WAIT, asynchronously between clock edges.
   -> mem_req=0, instr_valid=0, pc=RESET_PC before the next edge; a stale rvalid after release is ignored; the first request after release is at RESET_PC.
6. With FETCH_PERF_COUNT_EN, 3 fetches using 2-cycle gnt delay and ready=1.
   -> fetch_count=3; stall_count=9 (2 REQ-without-gnt cycles + 1 WAIT cycle per fetch).

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues single-outstanding word reads and hands instructions to decode.
// Optional performance counters are enabled by defining FETCH_PERF_COUNT_EN.
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'h0001
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [15:0] mem_rdata,
  output logic        instr_valid,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  input  logic        instr_ready,
  output logic [15:0] pc
`ifdef FETCH_PERF_COUNT_EN
  ,
  output logic [15:0] fetch_count,
  output logic [15:0] stall_count
`endif
);

  // state  | meaning
  // IDLE   | no fetch in progress, waiting for enable
  // REQ    | mem_req asserted at mem_addr, waiting for mem_gnt
  // WAIT   | request granted, waiting for mem_rvalid
  // HOLD   | instruction presented to decode, waiting for instr_ready
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state, state_d;
  logic [15:0] pc_d, req_addr, req_addr_d, instr_d, instr_pc_d, mem_addr_d;
  logic        discard, discard_d, mem_req_d, instr_valid_d;

  always_comb begin
    state_d    = state;
    pc_d       = pc;
    req_addr_d = req_addr;
    discard_d  = discard;
    instr_d    = instr;
    instr_pc_d = instr_pc;
    case (state)
      S_IDLE: begin
        if (redirect) pc_d = redirect_pc;
        if (enable) state_d = S_REQ;
      end
      S_REQ: begin
        if (mem_gnt) begin
          state_d    = S_WAIT;
          req_addr_d = pc;
          pc_d       = pc + PC_STEP;
          if (redirect) begin
            pc_d      = redirect_pc;
            discard_d = 1'b1;
          end
        end else if (redirect) begin
          pc_d = redirect_pc;
        end
      end
      S_WAIT: begin
        if (redirect) pc_d = redirect_pc;
        // A redirect coinciding with rvalid consumes that response; waiting on would deadlock.
        if (mem_rvalid) begin
          if (discard || redirect) begin
            discard_d = 1'b0;
            state_d   = enable ? S_REQ : S_IDLE;
          end else begin
            instr_d    = mem_rdata;
            instr_pc_d = req_addr;
            state_d    = S_HOLD;
          end
        end else if (redirect) begin
          discard_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = enable ? S_REQ : S_IDLE;
        end else if (instr_ready) begin
          state_d = enable ? S_REQ : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    mem_req_d     = (state_d == S_REQ);
    mem_addr_d    = (state_d == S_REQ) ? pc_d : mem_addr;
    instr_valid_d = (state_d == S_HOLD);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      mem_addr    <= RESET_PC;
      mem_req     <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= 16'h0000;
      instr_pc    <= 16'h0000;
      req_addr    <= 16'h0000;
      discard     <= 1'b0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      mem_addr    <= mem_addr_d;
      mem_req     <= mem_req_d;
      instr_valid <= instr_valid_d;
      instr       <= instr_d;
      instr_pc    <= instr_pc_d;
      req_addr    <= req_addr_d;
      discard     <= discard_d;
    end
  end

`ifdef FETCH_PERF_COUNT_EN
  logic stall_now;
  assign stall_now = (state == S_REQ && !mem_gnt) || (state == S_WAIT) ||
                     (state == S_HOLD && !instr_ready);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_count <= 16'h0000;
      stall_count <= 16'h0000;
    end else begin
      if (instr_valid && instr_ready) fetch_count <= fetch_count + 16'h0001;
      if (stall_now) stall_count <= stall_count + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed plus randomized bench for instr_fetch_unit; memory responses and expected
// addresses/data come from a simple address-sequence model (data = addr ^ 0xA5A5).
module tb_instr_fetch_unit;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic [15:0] pc;
`ifdef FETCH_PERF_COUNT_EN
  logic [15:0] fetch_count;
  logic [15:0] stall_count;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [15:0] exp_addr;
  int v1, v2, v3;

  instr_fetch_unit #(.RESET_PC(16'h0010), .PC_STEP(16'h0001)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .pc(pc)
`ifdef FETCH_PERF_COUNT_EN
    , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete fetch of address a: grant after gd cycles, data after rd cycles,
  // decode stalls yd cycles, then accepts with enable=en_after.
  task automatic fetch(input logic [15:0] a, input int gd, input int rd, input int yd,
                       input logic en_after, output int vcyc);
    logic [15:0] d;
    d = a ^ 16'hA5A5;
    for (int i = 0; i < 10 && !mem_req; i++) tick();
    check("req_seen", {15'd0, mem_req}, 16'd1);
    check("mem_addr", mem_addr, a);
    for (int i = 0; i < gd; i++) begin
      tick();
      check("req_hold", {15'd0, mem_req}, 16'd1);
      check("addr_hold", mem_addr, a);
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("req_drop", {15'd0, mem_req}, 16'd0);
    check("pc_inc", pc, a + 16'd1);
    for (int i = 1; i < rd; i++) begin
      tick();
      check("wait_novalid", {15'd0, instr_valid}, 16'd0);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = d;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = 16'($urandom);
    vcyc = cyc;
    check("valid", {15'd0, instr_valid}, 16'd1);
    check("instr", instr, d);
    check("instr_pc", instr_pc, a);
    for (int i = 0; i < yd; i++) begin
      tick();
      check("hold_valid", {15'd0, instr_valid}, 16'd1);
      check("hold_instr", instr, d);
      check("hold_pc", instr_pc, a);
      check("hold_noreq", {15'd0, mem_req}, 16'd0);
    end
    instr_ready = 1'b1;
    enable = en_after;
    tick();
    instr_ready = 1'b0;
    check("valid_clear", {15'd0, instr_valid}, 16'd0);
    check("next_req", {15'd0, mem_req}, {15'd0, en_after});
    if (en_after) check("next_addr", mem_addr, a + 16'd1);
    enable = 1'b1;
  endtask

  initial begin
    // Reset values
    tick();
    tick();
    check("rst_req", {15'd0, mem_req}, 16'd0);
    check("rst_addr", mem_addr, 16'h0010);
    check("rst_pc", pc, 16'h0010);
    check("rst_valid", {15'd0, instr_valid}, 16'd0);
    check("rst_instr", instr, 16'h0000);
    check("rst_ipc", instr_pc, 16'h0000);
    reset_n = 1'b1;
    enable  = 1'b1;
    tick();

    // Back-to-back fetches at minimum period
    fetch(16'h0010, 0, 1, 0, 1'b1, v1);
    fetch(16'h0011, 0, 1, 0, 1'b1, v2);
    fetch(16'h0012, 0, 1, 0, 1'b1, v3);
    check("period_a", 16'(v2 - v1), 16'd3);
    check("period_b", 16'(v3 - v2), 16'd3);

    // Decode stall of 5 cycles
    fetch(16'h0013, 0, 1, 5, 1'b1, v1);

    // Redirect during WAIT: the in-flight response is discarded
    check("t3_addr", mem_addr, 16'h0014);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    redirect = 1'b1;
    redirect_pc = 16'h0200;
    tick();
    redirect = 1'b0;
    check("t3_valid0", {15'd0, instr_valid}, 16'd0);
    check("t3_pc", pc, 16'h0200);
    tick();
    check("t3_valid1", {15'd0, instr_valid}, 16'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 16'hDEAD;
    tick();
    mem_rvalid = 1'b0;
    check("t3_valid2", {15'd0, instr_valid}, 16'd0);
    check("t3_req", {15'd0, mem_req}, 16'd1);
    fetch(16'h0200, 0, 1, 0, 1'b1, v1);

    // Redirect in REQ without grant, then wrap across 0xFFFF
    redirect = 1'b1;
    redirect_pc = 16'hFFFF;
    tick();
    redirect = 1'b0;
    check("t4_req", {15'd0, mem_req}, 16'd1);
    check("t4_addr", mem_addr, 16'hFFFF);
    fetch(16'hFFFF, 1, 1, 0, 1'b1, v1);
    fetch(16'h0000, 0, 2, 1, 1'b1, v1);

    // Redirect in REQ coinciding with grant
    redirect = 1'b1;
    redirect_pc = 16'h0300;
    mem_gnt = 1'b1;
    tick();
    redirect = 1'b0;
    mem_gnt = 1'b0;
    check("rg_req", {15'd0, mem_req}, 16'd0);
    check("rg_pc", pc, 16'h0300);
    mem_rvalid = 1'b1;
    mem_rdata  = 16'hBEEF;
    tick();
    mem_rvalid = 1'b0;
    check("rg_valid", {15'd0, instr_valid}, 16'd0);
    fetch(16'h0300, 0, 1, 0, 1'b1, v1);

    // Randomized timing against the sequential-address model
    exp_addr = 16'h0301;
    for (int n = 0; n < 12; n++) begin
      fetch(exp_addr, $urandom_range(0, 3), $urandom_range(1, 3), $urandom_range(0, 3),
            ($urandom_range(0, 3) != 0), v1);
      exp_addr = exp_addr + 16'd1;
    end

    // Asynchronous reset in the middle of WAIT
    for (int i = 0; i < 10 && !mem_req; i++) tick();
    check("t5_addr", mem_addr, exp_addr);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("t5_req", {15'd0, mem_req}, 16'd0);
    check("t5_valid", {15'd0, instr_valid}, 16'd0);
    check("t5_pc", pc, 16'h0010);
    tick();
    reset_n = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 16'h1234;
    tick();
    check("t5_stale0", {15'd0, instr_valid}, 16'd0);
    check("t5_addr2", mem_addr, 16'h0010);
    tick();
    mem_rvalid = 1'b0;
    check("t5_stale1", {15'd0, instr_valid}, 16'd0);
    fetch(16'h0010, 0, 1, 0, 1'b1, v1);

`ifdef FETCH_PERF_COUNT_EN
    reset_n = 1'b0;
    tick();
    check("pc_fc0", fetch_count, 16'd0);
    check("pc_sc0", stall_count, 16'd0);
    reset_n = 1'b1;
    fetch(16'h0010, 2, 1, 0, 1'b1, v1);
    fetch(16'h0011, 2, 1, 0, 1'b1, v1);
    fetch(16'h0012, 2, 1, 0, 1'b1, v1);
    check("fetch_count", fetch_count, 16'd3);
    check("stall_count", stall_count, 16'd9);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
